seven_segment_scan: RTL and testbench
=====================================

// Module: seven_segment_scan
// PURPOSE
//   Parametrised multi-digit decimal display driver for a common-segment 7-seg bank.
//   Converts an unsigned binary value to BCD sequentially (shift-add-3, one bit per clock),
//   saturating at the largest displayable value, and blanks leading zeros.
//   Time-multiplexes the digits: one digit enable at a time, with a programmable refresh rate.
//   Sits between the score/counter logic and the board's segment and digit-select pins.
// PARAMETERS
//   WIDTH        8     width of binary input number (>=1)
//   DIGITS       3     number of display digits (1..8); max shown value MAXV = 10^DIGITS-1
//   REFRESH_DIV  1024  clocks each digit stays enabled before the scan advances (>=1)
// PORTS
//   clk       in   1            rising-edge clock
//   reset     in   1            asynchronous, active-high reset
//   load      in   1            request conversion of number; accepted only when busy==0
//   number    in   WIDTH        unsigned value, sampled on the accepted load edge
//   busy      out  1            conversion in progress; load is ignored while high
//   overflow  out  1            1 = last accepted number exceeded MAXV (display saturated)
//   seg       out  7            segments {a,b,c,d,e,f,g}, active high, bit6 = a
//   digit_en  out  DIGITS       one-hot digit enable, active high; bit0 = ones digit
// BEHAVIOUR
//   Reset (async): busy=0, overflow=0, seg=7'b0000000, digit_en=0, displayed BCD=0,
//     scan index=0, refresh counter=0, conversion state discarded.
//   FSM: IDLE -> CONV (WIDTH cycles) -> IDLE.
//   - IDLE, load=1 at edge N: capture min(number, MAXV) into shift reg, clear BCD accum,
//     latch ovf_pend=(number>MAXV); busy=1 from N+1.
//   - CONV: each cycle, add 3 to every BCD nibble >=5, then shift {bcd,bin} left by 1.
//   - At edge N+WIDTH: displayed BCD <= accum and overflow <= ovf_pend (atomic update);
//     busy=0 from N+WIDTH+1. Latency load -> new display = WIDTH+1 cycles.
//   - load while busy: ignored, no queueing; number changes mid-CONV: no effect.
//   - Display never shows a partial conversion; old value is held until the atomic update.
//   - Accum is DIGITS nibbles; MAXV saturation guarantees no nibble overflow.
//     If 2^WIDTH-1 <= MAXV, the saturation compare is constant false.
//   Scan:
//   - refresh counter counts 0..REFRESH_DIV-1 and wraps.
//   - On wrap, scan index advances k -> k+1, and DIGITS-1 -> 0. Free-running, unaffected by busy.
//   - Outputs registered: digit_en = 1<<index and seg = decode(digit[index]), both updated
//     on the same edge, so no cycle mixes one digit's enable with another digit's pattern.
//   - Leading-zero blank: for index k>0, seg=0 if nibbles k..DIGITS-1 are all zero.
//     The ones digit always shows, so value 0 displays "0".
//   - Decode 0-9: 1111110 0110000 1101101 1111001 0110011 1011011 1011111 1110000
//     1111111 1110011. Any other nibble decodes to 0000000.
//   - Reset mid-conversion: conversion aborted, display 0, overflow 0.
//     First cycle after reset release: digit_en=...001, seg=1111110.
// TESTING
//   1 Reset: assert reset mid-CONV -> busy=0, overflow=0, seg=0, digit_en=0 immediately
//     (async). After release -> ones digit shows "0" (1111110).
//   2 WIDTH=8, DIGITS=3: load 255 -> busy high 8 cycles, update at edge N+8.
//     Scan shows ones 1011011, tens 1011011, hundreds 1101101; overflow=0.
//   3 Leading zeros, DIGITS=3: load 7 -> hundreds and tens seg=0000000, ones=1110000.
//     Load 0 -> only ones shows 1111110.
//   4 Saturation, WIDTH=8, DIGITS=2: load 200 -> display "99" (1110011 on both), overflow=1.
//     Then load 42 -> overflow=0.
//   5 Handshake: load 12, then load 99 at N+3 while busy -> 99 ignored, display "12",
//     busy=0 from N+9.
//   6 Scan, REFRESH_DIV=4, DIGITS=3: digit_en steps 001 -> 010 -> 100 -> 001, every 4 clocks.
//     Exactly one bit set after the first post-reset edge; seg changes only on the same edges.

Source files
------------

// File: rtl/seven_segment_scan.sv
// rtl/seven_segment_scan.sv - binary to multiplexed 7-segment decimal display driver
//
// Converts an unsigned binary value to BCD with a sequential shift-add-3 engine
// (one bit per clock). The value saturates at 10^DIGITS-1, and leading zeros are blanked.
// The digits are scanned one at a time, and each digit stays enabled for REFRESH_DIV clocks.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-high reset
//   load      conversion request, accepted only while busy is low
//   number    unsigned value, sampled on the accepted load edge
//   busy      conversion in progress
//   overflow  last accepted number exceeded the displayable maximum
//   seg       segments {a,b,c,d,e,f,g}, active high
//   digit_en  one-hot digit enable, bit0 = ones digit
module seven_segment_scan #(
    parameter int WIDTH       = 8,
    parameter int DIGITS      = 3,
    parameter int REFRESH_DIV = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WIDTH-1:0]  number,
    output logic              busy,
    output logic              overflow,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] digit_en
);

    localparam int BW    = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int RW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW    = (WIDTH > 64) ? WIDTH : 64;
    localparam logic [63:0] MAXV = 64'(10 ** DIGITS) - 64'd1;

    typedef enum logic {S_IDLE, S_CONV} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   bin_q, bin_d;
    logic [BW-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic [BW-1:0]      disp_q, disp_d;
    logic               ovf_q, ovf_d;

    logic [RW-1:0]      ref_q, ref_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [6:0]         seg_q, seg_d;
    logic [DIGITS-1:0]  en_q, en_d;

    logic                  over;
    logic [BW-1:0]         adj;
    logic [BW+WIDTH-1:0]   shifted;
    logic                  ref_wrap;
    logic                  upper_nz;
    logic [3:0]            nibble;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1111110;
            4'd1:    decode = 7'b0110000;
            4'd2:    decode = 7'b1101101;
            4'd3:    decode = 7'b1111001;
            4'd4:    decode = 7'b0110011;
            4'd5:    decode = 7'b1011011;
            4'd6:    decode = 7'b1011111;
            4'd7:    decode = 7'b1110000;
            4'd8:    decode = 7'b1111111;
            4'd9:    decode = 7'b1110011;
            default: decode = 7'b0000000;
        endcase
    endfunction

    // Conversion FSM
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        disp_d     = disp_q;
        ovf_d      = ovf_q;

        // Constant false when every WIDTH-bit value fits on the display.
        over = CW'(number) > CW'(MAXV);

        adj = acc_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
        shifted = {adj, bin_q} << 1;

        case (state_q)
            S_IDLE: begin
                if (load) begin
                    state_d    = S_CONV;
                    bin_d      = over ? WIDTH'(MAXV) : number;
                    acc_d      = '0;
                    cnt_d      = '0;
                    ovf_pend_d = over;
                end
            end
            S_CONV: begin
                acc_d = shifted[BW+WIDTH-1:WIDTH];
                bin_d = shifted[WIDTH-1:0];
                cnt_d = cnt_q + CNT_W'(1);
                // The last shift goes straight to the display together with
                // the overflow flag, so no partial result is ever visible.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_IDLE;
                    disp_d  = shifted[BW+WIDTH-1:WIDTH];
                    ovf_d   = ovf_pend_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Scan and segment decode
    always_comb begin
        ref_wrap = (ref_q == RW'(REFRESH_DIV - 1));
        ref_d    = ref_wrap ? '0 : ref_q + RW'(1);
        idx_d    = idx_q;
        if (ref_wrap) begin
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end

        upper_nz = 1'b0;
        for (int j = 0; j < DIGITS; j++) begin
            if (j >= int'(idx_q) && disp_q[4*j +: 4] != 4'd0) begin
                upper_nz = 1'b1;
            end
        end
        nibble = disp_q[4*int'(idx_q) +: 4];

        // Enable and pattern come from the same index, so they change together.
        en_d  = DIGITS'(1) << idx_q;
        seg_d = (idx_q != '0 && !upper_nz) ? 7'b0000000 : decode(nibble);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            bin_q      <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            disp_q     <= '0;
            ovf_q      <= 1'b0;
            ref_q      <= '0;
            idx_q      <= '0;
            seg_q      <= '0;
            en_q       <= '0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            disp_q     <= disp_d;
            ovf_q      <= ovf_d;
            ref_q      <= ref_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            en_q       <= en_d;
        end
    end

    assign busy     = (state_q == S_CONV);
    assign overflow = ovf_q;
    assign seg      = seg_q;
    assign digit_en = en_q;

endmodule

// File: tb/tb_seven_segment_scan.sv
// tb/tb_seven_segment_scan.sv - scoreboard bench for seven_segment_scan
module tb_seven_segment_scan;

    localparam logic [6:0] D0 = 7'b1111110, D1 = 7'b0110000, D2 = 7'b1101101;
    localparam logic [6:0] D4 = 7'b0110011, D5 = 7'b1011011;
    localparam logic [6:0] D7 = 7'b1110000, D9 = 7'b1110011, BL = 7'b0000000;

    typedef struct packed {
        logic        ovf1;
        logic [20:0] segs1;   // {hundreds, tens, ones}
        logic        ovf2;
        logic [13:0] segs2;   // {tens, ones}
    } exp_t;

    logic       clk, reset, load;
    logic [7:0] number;
    logic       busy1, ovf1, busy2, ovf2;
    logic [6:0] seg1, seg2;
    logic [2:0] en1;
    logic [1:0] en2;

    int   errors = 0;
    int   checks = 0;
    int   mon_done = 0;
    exp_t sb[$];

    seven_segment_scan #(.WIDTH(8), .DIGITS(3), .REFRESH_DIV(4)) u_dut3 (
        .clk(clk), .reset(reset), .load(load), .number(number),
        .busy(busy1), .overflow(ovf1), .seg(seg1), .digit_en(en1)
    );

    seven_segment_scan #(.WIDTH(8), .DIGITS(2), .REFRESH_DIV(4)) u_dut2 (
        .clk(clk), .reset(reset), .load(load), .number(number),
        .busy(busy2), .overflow(ovf2), .seg(seg2), .digit_en(en2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic o1, input logic [6:0] h, input logic [6:0] t,
                                input logic [6:0] o, input logic o2, input logic [6:0] t2,
                                input logic [6:0] on2);
        exp_t e;
        e.ovf1  = o1;
        e.segs1 = {h, t, o};
        e.ovf2  = o2;
        e.segs2 = {t2, on2};
        return e;
    endfunction

    // Monitor: a busy falling edge marks a finished conversion; pop the expectation,
    // then watch one full scan of both displays.
    initial begin
        logic busy_prev;
        int   run;
        exp_t e;
        logic [6:0] s1 [3];
        logic [6:0] s2 [2];
        logic oh_ok;
        busy_prev = 1'b0;
        run = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy_prev = 1'b0;
                run = 0;
            end else if (busy1) begin
                busy_prev = 1'b1;
                run++;
            end else if (busy_prev) begin
                busy_prev = 1'b0;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got completion expected none");
                end else begin
                    e = sb.pop_front();
                    chk("busy_cycles", 32'(run), 32'd8);
                    chk("overflow3", 32'(ovf1), 32'(e.ovf1));
                    chk("overflow2", 32'(ovf2), 32'(e.ovf2));
                    for (int d = 0; d < 3; d++) s1[d] = 7'bx;
                    for (int d = 0; d < 2; d++) s2[d] = 7'bx;
                    oh_ok = 1'b1;
                    repeat (12) begin
                        @(negedge clk);
                        for (int d = 0; d < 3; d++) if (en1 == 3'(1 << d)) s1[d] = seg1;
                        for (int d = 0; d < 2; d++) if (en2 == 2'(1 << d)) s2[d] = seg2;
                        if (!$onehot(en1) || !$onehot(en2)) oh_ok = 1'b0;
                    end
                    chk("onehot", 32'(oh_ok), 32'd1);
                    chk("d3_ones", 32'(s1[0]), 32'(e.segs1[6:0]));
                    chk("d3_tens", 32'(s1[1]), 32'(e.segs1[13:7]));
                    chk("d3_hund", 32'(s1[2]), 32'(e.segs1[20:14]));
                    chk("d2_ones", 32'(s2[0]), 32'(e.segs2[6:0]));
                    chk("d2_tens", 32'(s2[1]), 32'(e.segs2[13:7]));
                end
                run = 0;
                mon_done++;
            end
        end
    end

    task automatic do_load(input logic [7:0] n, input exp_t e);
        @(negedge clk);
        number = n;
        load   = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        load   = 1'b0;
        number = ~n;
    endtask

    task automatic wait_done();
        int start;
        bit got;
        start = mon_done;
        got = 1'b0;
        for (int k = 0; k < 80 && !got; k++) begin
            @(negedge clk);
            if (mon_done != start) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no completion expected one within 80 cycles");
            sb.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        load   = 1'b0;
        number = 8'd0;
        #1;
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_ovf", 32'(ovf1), 32'd0);
        chk("rst_seg", 32'(seg1), 32'd0);
        chk("rst_en", 32'(en1), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Free-running scan straight out of reset with value 0 shown.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("scan_en3", 32'(en1), 32'(1 << ((i / 4) % 3)));
            chk("scan_seg3", 32'(seg1), 32'((((i / 4) % 3) == 0) ? D0 : BL));
            chk("scan_en2", 32'(en2), 32'(1 << ((i / 4) % 2)));
        end

        do_load(8'd255, mk(1'b0, D2, D5, D5, 1'b1, D9, D9)); wait_done();
        do_load(8'd7,   mk(1'b0, BL, BL, D7, 1'b0, BL, D7)); wait_done();
        do_load(8'd0,   mk(1'b0, BL, BL, D0, 1'b0, BL, D0)); wait_done();
        do_load(8'd200, mk(1'b0, D2, D0, D0, 1'b1, D9, D9)); wait_done();
        do_load(8'd42,  mk(1'b0, BL, D4, D2, 1'b0, D4, D2)); wait_done();
        do_load(8'd99,  mk(1'b0, BL, D9, D9, 1'b0, D9, D9)); wait_done();
        do_load(8'd100, mk(1'b0, D1, D0, D0, 1'b1, D9, D9)); wait_done();

        // Load while busy must be dropped.
        do_load(8'd12, mk(1'b0, BL, D1, D2, 1'b0, D1, D2));
        repeat (2) @(negedge clk);
        number = 8'd99;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
        wait_done();

        do_load(8'd105, mk(1'b0, D1, D0, D5, 1'b1, D9, D9)); wait_done();

        // Reset in the middle of a conversion.
        @(negedge clk);
        number = 8'd200;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
        repeat (2) @(negedge clk);
        chk("midconv_busy", 32'(busy1), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", 32'(busy1), 32'd0);
        chk("arst_ovf2", 32'(ovf2), 32'd0);
        chk("arst_seg", 32'(seg1), 32'd0);
        chk("arst_en", 32'(en1), 32'd0);
        chk("arst_seg2", 32'(seg2), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_en", 32'(en1), 32'd1);
        chk("post_seg", 32'(seg1), 32'(D0));
        chk("post_busy", 32'(busy1), 32'd0);
        repeat (12) @(negedge clk);
        chk("post_ovf2", 32'(ovf2), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
